// File: rtl/dcache_dma.sv
// DMA sequencer in front of dcache: streams words into a slot (load) or out of a slot (store).
// Optional transfer statistics counter enabled by defining DCACHE_DMA_STATS_EN.
module dcache_dma #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 18,
  parameter int SLOT_W = 2,
  parameter int LEN_W  = 12
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_dir,
  input  logic [SLOT_W-1:0]                cmd_slot,
  input  logic [ADDR_W-1:0]                cmd_addr,
  input  logic [LEN_W-1:0]                 cmd_len,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_W-1:0]                in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_W-1:0]                out_data,
  output logic [SLOT_W+ADDR_W+DATA_W:0]    dma_write_port,
  output logic [SLOT_W+ADDR_W:0]           dma_read_port_in,
  input  logic [DATA_W:0]                  dma_read_port_out,
  output logic                             busy,
  output logic                             done,
  output logic [31:0]                      xfer_count
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

  state_t              state;
  logic [SLOT_W-1:0]   slot;
  logic [ADDR_W-1:0]   cur_addr;
  logic [ADDR_W-1:0]   rd_addr;
  logic [LEN_W-1:0]    len;
  logic [LEN_W-1:0]    cnt;
  logic [LEN_W-1:0]    issued;

  logic [DATA_W-1:0]   fifo_mem [2];
  logic                fifo_rd;
  logic                fifo_wr;
  logic [1:0]          fifo_count;
  logic [1:0]          inflight;

  logic                in_hs;
  logic                pop;
  logic                push;
  logic                issue;
  logic [2:0]          occ;
  logic [2:0]          limit;
  logic [DATA_W-1:0]   dat_r;
  logic                read_complete;

  assign dat_r         = dma_read_port_out[DATA_W:1];
  assign read_complete = dma_read_port_out[0];

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign in_ready  = (state == LOAD);
  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = fifo_mem[fifo_rd];

  // Handshakes and read-issue throttle: a new read must still fit after this cycle's pop.
  always_comb begin
    in_hs = in_valid && (state == LOAD);
    pop   = out_valid && out_ready;
    push  = read_complete && (state == STORE);
    occ   = {1'b0, fifo_count} + {1'b0, inflight} + 3'd1;
    limit = 3'd2 + {2'b00, pop};
    if ((state == STORE) && (issued < len) && (occ <= limit)) begin
      issue = 1'b1;
    end else begin
      issue = 1'b0;
    end
    if (issue) begin
      dma_read_port_in = {slot, rd_addr, 1'b1};
    end else begin
      dma_read_port_in = '0;
    end
  end

  // Transfer FSM, address/length counters and the registered dcache write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      slot           <= '0;
      cur_addr       <= '0;
      rd_addr        <= '0;
      len            <= '0;
      cnt            <= '0;
      issued         <= '0;
      dma_write_port <= '0;
    end else begin
      if (in_hs) begin
        dma_write_port <= {slot, cur_addr, 1'b1, in_data};
      end else begin
        dma_write_port <= '0;
      end
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            slot     <= cmd_slot;
            cur_addr <= cmd_addr;
            rd_addr  <= cmd_addr;
            len      <= cmd_len;
            cnt      <= '0;
            issued   <= '0;
            if (cmd_len == '0) begin
              state <= DONE;
            end else if (cmd_dir) begin
              state <= STORE;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (in_hs) begin
            cur_addr <= cur_addr + ADDR_W'(1);
            cnt      <= cnt + LEN_W'(1);
            if ((cnt + LEN_W'(1)) == len) begin
              state <= DONE;
            end
          end
        end
        STORE: begin
          if (issue) begin
            rd_addr <= rd_addr + ADDR_W'(1);
            issued  <= issued + LEN_W'(1);
          end
          if (pop) begin
            cnt <= cnt + LEN_W'(1);
            if ((cnt + LEN_W'(1)) == len) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Two-entry read-data buffer plus count of reads still in flight at the dcache.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      fifo_rd     <= 1'b0;
      fifo_wr     <= 1'b0;
      fifo_count  <= 2'd0;
      inflight    <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[fifo_wr] <= dat_r;
        fifo_wr           <= ~fifo_wr;
      end
      if (pop) begin
        fifo_rd <= ~fifo_rd;
      end
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
      inflight   <= inflight + {1'b0, issue} - {1'b0, push};
    end
  end

`ifdef DCACHE_DMA_STATS_EN
  logic [31:0] xfer_cnt;

  // Words moved since reset: one per load write issued, one per store word popped.
  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_cnt <= 32'd0;
    end else begin
      xfer_cnt <= xfer_cnt + {31'd0, in_hs} + {31'd0, pop};
    end
  end

  assign xfer_count = xfer_cnt;
`else
  assign xfer_count = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_dma.sv
// Directed bench for dcache_dma with a behavioural dcache and queue-based scoreboards.
module tb_dcache_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_dir;
  logic [1:0]  cmd_slot;
  logic [10:0] cmd_addr;
  logic [11:0] cmd_len;
  logic        in_valid, in_ready;
  logic [17:0] in_data;
  logic        out_valid, out_ready;
  logic [17:0] out_data;
  logic [31:0] dma_write_port;
  logic [13:0] dma_read_port_in;
  logic [18:0] dma_read_port_out;
  logic        busy, done;
  logic [31:0] xfer_count;

  dcache_dma dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_slot(cmd_slot), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .dma_write_port(dma_write_port), .dma_read_port_in(dma_read_port_in),
    .dma_read_port_out(dma_read_port_out),
    .busy(busy), .done(done), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  logic [17:0] cmem    [0:8191];
  logic [17:0] ref_mem [0:8191];
  logic [31:0] wq[$];
  logic [17:0] oq[$];
  int n_re, n_pop, first_re, first_ov, last_pop;
  logic [31:0] exp_xfer = 32'd0;

  wire we = dma_write_port[18];
  wire re = dma_read_port_in[0];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] xfer_exp();
`ifdef DCACHE_DMA_STATS_EN
    return exp_xfer;
`else
    return 32'd0;
`endif
  endfunction

  // Behavioural dcache: write on we, one-cycle read latency.
  always @(posedge clk) begin
    cyc++;
    if (we) cmem[{dma_write_port[31:30], dma_write_port[29:19]}] <= dma_write_port[17:0];
    dma_read_port_out <= {cmem[{dma_read_port_in[13:12], dma_read_port_in[11:1]}], re};
  end

  // Monitor: scoreboard pops and the read-throttle check, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset || !busy) begin
      n_re = 0; n_pop = 0; first_re = -1; first_ov = -1; last_pop = -1;
    end
    if (!reset) begin
      if (we) begin
        if (wq.size() == 0) chk("unexpected_we", {32'd0, dma_write_port}, 64'd0);
        else chk("write_port", {32'd0, dma_write_port}, {32'd0, wq.pop_front()});
      end
      if (re) begin
        chk("re_throttle", 64'((n_re - n_pop - ((out_valid && out_ready) ? 1 : 0) + 1) <= 2), 64'd1);
        if (first_re < 0) first_re = cyc;
        n_re++;
      end
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (out_valid && out_ready) begin
        if (oq.size() == 0) chk("unexpected_pop", {46'd0, out_data}, 64'd0);
        else chk("out_data", {46'd0, out_data}, {46'd0, oq.pop_front()});
        n_pop++;
        last_pop = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic dir, input logic [1:0] s, input logic [10:0] a, input logic [11:0] l);
    bit ok = 0;
    cmd_dir = dir; cmd_slot = s; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) begin n_chk++; $error("FAIL cmd_timeout: got cmd_ready=0 expected 1"); end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic finish_xfer(input string tag);
    chk({tag, "_done_pulse"}, {63'd0, done}, 64'd1);
    tick();
    @(negedge clk);
    chk({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd1);
    chk({tag, "_done_low"}, {63'd0, done}, 64'd0);
    chk({tag, "_xfer"}, {32'd0, xfer_count}, {32'd0, xfer_exp()});
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [1:0] s, input logic [10:0] a, input int l, input logic [17:0] base);
    logic [10:0] ad;
    bit ok;
    send_cmd(1'b0, s, a, 12'(l));
    ad = a;
    for (int i = 0; i < l; i++) begin
      in_valid = 1'b1; in_data = base + 18'(i);
      wq.push_back({s, ad, 1'b1, in_data});
      ref_mem[{s, ad}] = in_data;
      ad = ad + 11'd1;
      ok = 0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (in_ready) begin ok = 1; break; end
      end
      if (!ok) begin n_chk++; $error("FAIL in_timeout: got in_ready=0 expected 1"); end
      tick();
    end
    in_valid = 1'b0;
    exp_xfer += 32'(l);
    @(negedge clk);
    chk("load_last_we", {63'd0, we}, 64'd1);
    finish_xfer("load");
  endtask

  task automatic do_store(input logic [1:0] s, input logic [10:0] a, input int l, input int mode);
    int p = 0;
    bit ok = 0;
    for (int i = 0; i < l; i++) oq.push_back(ref_mem[{s, a + 11'(i)}]);
    out_ready = 1'b1;
    send_cmd(1'b1, s, a, 12'(l));
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
      @(posedge clk); #1;
      p++;
      out_ready = (mode == 0) || (p % 4 == 0) || (p % 4 == 3);
    end
    out_ready = 1'b0;
    if (!ok) begin n_chk++; $error("FAIL store_timeout: got done=0 expected 1"); end
    chk("store_all_out", 64'(oq.size()), 64'd0);
    if (mode == 0) begin
      chk("store_first_latency", 64'(first_ov - first_re), 64'd2);
      chk("store_back_to_back", 64'(last_pop - first_ov), 64'(l - 1));
    end
    exp_xfer += 32'(l);
    finish_xfer("store");
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_slot = 2'd0; cmd_addr = 11'd0;
    cmd_len = 12'd0; in_valid = 1'b0; in_data = 18'd0; out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", {46'd0, out_data}, 64'd0);
    chk("rst_wport", {32'd0, dma_write_port}, 64'd0);
    chk("rst_rport", {50'd0, dma_read_port_in}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_xfer", {32'd0, xfer_count}, 64'd0);
    tick();

    // Single-word load, then wrapping load.
    do_load(2'd2, 11'd0, 1, 18'd3423);
    chk("mem_s2_a0", {46'd0, cmem[{2'd2, 11'd0}]}, 64'd3423);
    do_load(2'd1, 11'd2046, 4, 18'd10);
    chk("mem_s1_a0", {46'd0, cmem[{2'd1, 11'd0}]}, 64'd12);
    chk("mem_s1_a1", {46'd0, cmem[{2'd1, 11'd1}]}, 64'd13);
    chk("mem_s1_a2047", {46'd0, cmem[{2'd1, 11'd2047}]}, 64'd11);

    // Store with sink always ready, then with backpressure.
    do_store(2'd1, 11'd2046, 4, 0);
    do_load(2'd3, 11'd500, 8, 18'd100);
    do_store(2'd3, 11'd500, 8, 1);

    // Zero-length commands.
    for (int d = 0; d < 2; d++) begin
      send_cmd(d[0], 2'd0, 11'd5, 12'd0);
      @(negedge clk);
      chk("len0_no_we", {63'd0, we}, 64'd0);
      chk("len0_no_re", {63'd0, re}, 64'd0);
      finish_xfer("len0");
    end

    // Reset in the middle of a store.
    for (int i = 0; i < 8; i++) oq.push_back(ref_mem[{2'd3, 11'd500 + 11'(i)}]);
    out_ready = 1'b1;
    send_cmd(1'b1, 2'd3, 11'd500, 12'd8);
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (n_pop >= 2) break;
    end
    chk("pre_reset_pops", 64'(n_pop), 64'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0; out_ready = 1'b0;
    oq.delete();
    exp_xfer = 32'd0;
    @(negedge clk);
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_re", {63'd0, re}, 64'd0);
    chk("mid_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("mid_rst_xfer", {32'd0, xfer_count}, 64'd0);
    tick();
    do_load(2'd2, 11'd7, 3, 18'd200);
    chk("mem_s2_a9", {46'd0, cmem[{2'd2, 11'd9}]}, 64'd202);
    chk("wq_drained", 64'(wq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dcache_dma.md
# dcache_dma

DMA sequencer that sits directly upstream of `dcache` and is the only master of its DMA ports. Accepts one transfer command at a time. Load commands stream 18-bit words from an external valid/ready source into one dcache slot. Store commands read a dcache slot and stream the words out through a valid/ready sink, absorbing the dcache's 1-cycle read latency and sink backpressure in a 2-entry buffer.

## Interface
- `ADDR_W`, 11, dcache word address width
- `DATA_W`, 18, word width
- `SLOT_W`, 2, slot select width
- `LEN_W`, 12, transfer length width in words (max 2048)

- `clk`  in  1  clock; everything on posedge
- `reset`  in  1  synchronous, active-high
- `cmd_valid` / `cmd_ready`  in / out  1 / 1  command handshake
- `cmd_dir`  in  1  0 = load (stream→dcache), 1 = store (dcache→stream)
- `cmd_slot`  in  SLOT_W  target slot
- `cmd_addr`  in  ADDR_W  start word address
- `cmd_len`  in  LEN_W  word count, 0..2048
- `in_valid` / `in_ready` / `in_data`  in / out / in  1 / 1 / DATA_W  load source stream
- `out_valid` / `out_ready` / `out_data`  out / in / out  1 / 1 / DATA_W  store sink stream
- `dma_write_port`  out  SLOT_W+ADDR_W+1+DATA_W  {slot, addr, we, dat_w} to dcache
- `dma_read_port_in`  out  SLOT_W+ADDR_W+1  {slot, addr, re} to dcache
- `dma_read_port_out`  in  DATA_W+1  {dat_r, read_complete} from dcache
- `busy`  out  1  high in any state but IDLE
- `done`  out  1  one-cycle pulse at transfer end
- `xfer_count`  out  32  total words moved since reset (see Configuration)

## Operation
- FSM: IDLE, LOAD, STORE, DONE. Reset → IDLE.
- IDLE: `cmd_ready`=1. On handshake, latch slot/addr/len and zero counters.
  - len=0 → DONE.
  - dir=0 → LOAD; dir=1 → STORE.
- LOAD:
  - `in_ready`=1. Each in handshake registers {slot, cur_addr, we=1, in_data} onto `dma_write_port` for the following cycle.
  - cur_addr then increments.
  - After the len-th handshake → DONE; the final write lands during DONE.
- STORE:
  - Read issue: `re`=1 with {slot, rd_addr} when issued<len AND fifo_count + inflight − pop + 1 ≤ 2. `pop` = out handshake this cycle.
  - rd_addr increments per issue.
  - When `read_complete`=1, `dat_r` is pushed to the FIFO.
  - `out_valid` = FIFO non-empty. `out_data` = FIFO head.
  - After the len-th out handshake → DONE.
- DONE: `done`=1 for one cycle, `cmd_ready`=0, then IDLE.
- Addresses wrap modulo 2^ADDR_W: 2047+1 → 0. Slot never changes mid-transfer.
- `we` and `re` are never asserted outside LOAD/DONE and STORE respectively.
- `read_complete` is ignored outside STORE.
- Commands arriving while busy are not accepted (`cmd_ready`=0) and remain pending on the interface.

## Timing
- Reset values: `cmd_ready`=1, `in_ready`=0, `out_valid`=0, `out_data`=0, all `dma_write_port` fields 0 (we=0), all `dma_read_port_in` fields 0 (re=0), `busy`=0, `done`=0, `xfer_count`=0.
- Reset asserted mid-transfer: next cycle IDLE; FIFO, counters and outputs at reset values; in-flight read data dropped.
- Load: in handshake at cycle t → `we`=1 at cycle t+1 → dcache write at the posedge ending t+1. Throughput 1 word/cycle.
- Store: `re` at cycle t → `read_complete` at t+1 → `out_valid` at t+2. Sustains 1 word/cycle with `out_ready` held high.
- `out_valid`/`out_data` stay stable until accepted.
- `done` rises the cycle after the last in/out handshake (len=0: the cycle after the command handshake). `cmd_ready` returns the cycle after that.

## Configuration
- `DCACHE_DMA_STATS_EN` defined: `xfer_count` increments by 1 per load write issued and per store word popped. It wraps at 2^32 and is cleared only by `reset`.
- Not defined: `xfer_count` is tied to 0 and no counter logic is built.

## Test plan
- Load slot 2, addr 0, len 1, in_data 3423 → `dma_write_port` = {2, 0, 1, 3423} one cycle after handshake; `done` pulses; dcache slot 2 addr 0 reads 3423.
- Load slot 1, addr 2046, len 4, data 10..13 → writes to addr 2046, 2047, 0, 1; `xfer_count`=4 with STATS_EN, 0 without.
- Store slot 1, addr 2046, len 4, `out_ready` held 1 → `out_data` 10, 11, 12, 13 on 4 consecutive cycles, first one 2 cycles after first `re`.
- Store len 8 with `out_ready` toggling 1,0,0,1,… → all 8 words out in order, none lost or duplicated; `re` never issued with 2 words buffered and 0 popping.
- Command len 0 → no `we`/`re`; `done` the cycle after handshake; `cmd_ready` high one cycle later.
- Reset asserted during store word 3 of 8 → next cycle `out_valid`=0, `re`=0, `cmd_ready`=1; new load command accepted normally.
